// File: rtl/wb_lane_serializer.sv
// MEM/WB write-back serializer: retires one captured bundle through the register
// file port, the position-register port and the pixel valid/ready sink, one lane per cycle.
module wb_lane_serializer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int LANES  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              wr_pxl_in,
  input  logic              wr_pos_in,
  input  logic              wr_mul_reg_in,
  input  logic              wr_mul_pos_in,
  input  logic [ADDR_W-1:0] rd_in,
  input  logic [DATA_W-1:0] r1_in,
  input  logic [DATA_W-1:0] r2_in,
  input  logic [DATA_W-1:0] r3_in,
  input  logic [DATA_W-1:0] r4_in,
  input  logic [DATA_W-1:0] load1_in,
  input  logic [DATA_W-1:0] load2_in,
  input  logic [DATA_W-1:0] load3_in,
  input  logic [DATA_W-1:0] load4_in,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              pos_we,
  output logic [1:0]        pos_waddr,
  output logic [DATA_W-1:0] pos_wdata,
  output logic              pxl_valid,
  input  logic              pxl_ready,
  output logic [DATA_W-1:0] pxl_data,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, MREG, MPOS, SPOS, PXL} state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  // Pending phases: [0] MREG, [1] MPOS, [2] SPOS, [3] PXL
  logic [3:0]        flg_q, flg_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] r_q  [LANES];
  logic [DATA_W-1:0] r_d  [LANES];
  logic [DATA_W-1:0] ld_q [LANES];
  logic [DATA_W-1:0] ld_d [LANES];

  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              pos_we_q, pos_we_d;
  logic [1:0]        pos_waddr_q, pos_waddr_d;
  logic [DATA_W-1:0] pos_wdata_q, pos_wdata_d;
  logic              pxl_valid_q, pxl_valid_d;
  logic [DATA_W-1:0] pxl_data_q, pxl_data_d;
  logic              done_q, done_d;

  function automatic state_t first_phase(input logic [3:0] f);
    if (f[0]) return MREG;
    if (f[1]) return MPOS;
    if (f[2]) return SPOS;
    if (f[3]) return PXL;
    return IDLE;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flg_d   = flg_q;
    rd_d    = rd_q;
    r_d     = r_q;
    ld_d    = ld_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          rd_d  = rd_in;
          r_d   = '{r1_in, r2_in, r3_in, r4_in};
          ld_d  = '{load1_in, load2_in, load3_in, load4_in};
          flg_d = {wr_pxl_in, wr_pos_in, wr_mul_pos_in, wr_mul_reg_in};
          cnt_d = 2'd0;
          state_d = first_phase(flg_d);
        end
      end
      MREG: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          flg_d[0] = 1'b0;
          state_d  = first_phase(flg_d);
        end
      end
      MPOS: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          flg_d[1] = 1'b0;
          state_d  = first_phase(flg_d);
        end
      end
      SPOS: begin
        flg_d[2] = 1'b0;
        state_d  = first_phase(flg_d);
      end
      PXL: begin
        if (pxl_ready) begin
          flg_d[3] = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered: decode them from the state the next cycle will be in.
    rf_we_d     = (state_d == MREG);
    rf_waddr_d  = rf_we_d ? rd_d + ADDR_W'(cnt_d) : '0;
    rf_wdata_d  = rf_we_d ? ld_d[cnt_d] : '0;
    pos_we_d    = (state_d == MPOS) || (state_d == SPOS);
    pos_waddr_d = (state_d == MPOS) ? cnt_d : (state_d == SPOS) ? rd_d[1:0] : 2'd0;
    pos_wdata_d = (state_d == MPOS) ? r_d[cnt_d] : (state_d == SPOS) ? r_d[0] : '0;
    pxl_valid_d = (state_d == PXL);
    pxl_data_d  = pxl_valid_d ? ld_d[0] : '0;
    done_d      = ((state_d == MREG) && (cnt_d == 2'd3) && (flg_d[3:1] == 3'd0)) ||
                  ((state_d == MPOS) && (cnt_d == 2'd3) && (flg_d[3:2] == 2'd0)) ||
                  ((state_d == SPOS) && !flg_d[3]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      flg_q       <= '0;
      rd_q        <= '0;
      r_q         <= '{default: '0};
      ld_q        <= '{default: '0};
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      pos_we_q    <= 1'b0;
      pos_waddr_q <= '0;
      pos_wdata_q <= '0;
      pxl_valid_q <= 1'b0;
      pxl_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      flg_q       <= flg_d;
      rd_q        <= rd_d;
      r_q         <= r_d;
      ld_q        <= ld_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      pos_we_q    <= pos_we_d;
      pos_waddr_q <= pos_waddr_d;
      pos_wdata_q <= pos_wdata_d;
      pxl_valid_q <= pxl_valid_d;
      pxl_data_q  <= pxl_data_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = (state_q == IDLE) & rst;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign pos_we    = pos_we_q;
  assign pos_waddr = pos_waddr_q;
  assign pos_wdata = pos_wdata_q;
  assign pxl_valid = pxl_valid_q;
  assign pxl_data  = pxl_data_q;
  // The pixel handshake can only finish in the cycle the sink accepts, so that done is not registered.
  assign done      = done_q | ((state_q == PXL) & pxl_ready);

endmodule

// File: tb/tb_wb_lane_serializer.sv
// Randomized bench for wb_lane_serializer: each bundle is expanded into the expected
// per-cycle output sequence from the write-back rules and compared cycle by cycle.
module tb_wb_lane_serializer;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              wr_pxl_in = 1'b0, wr_pos_in = 1'b0, wr_mul_reg_in = 1'b0, wr_mul_pos_in = 1'b0;
  logic [ADDR_W-1:0] rd_in = '0;
  logic [DATA_W-1:0] r1_in = '0, r2_in = '0, r3_in = '0, r4_in = '0;
  logic [DATA_W-1:0] load1_in = '0, load2_in = '0, load3_in = '0, load4_in = '0;
  logic              rf_we, pos_we, pxl_valid, done;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata, pos_wdata, pxl_data;
  logic [1:0]        pos_waddr;
  logic              pxl_ready = 1'b0;

  always #5 clk = ~clk;

  wb_lane_serializer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .wr_pxl_in(wr_pxl_in), .wr_pos_in(wr_pos_in), .wr_mul_reg_in(wr_mul_reg_in),
    .wr_mul_pos_in(wr_mul_pos_in), .rd_in(rd_in),
    .r1_in(r1_in), .r2_in(r2_in), .r3_in(r3_in), .r4_in(r4_in),
    .load1_in(load1_in), .load2_in(load2_in), .load3_in(load3_in), .load4_in(load4_in),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pos_we(pos_we), .pos_waddr(pos_waddr), .pos_wdata(pos_wdata),
    .pxl_valid(pxl_valid), .pxl_ready(pxl_ready), .pxl_data(pxl_data), .done(done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pk(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                                      input logic pwe, input logic [1:0] pwa, input logic [31:0] pwd,
                                      input logic pv, input logic [31:0] pd, input logic dn,
                                      input logic rdy);
    return {21'd0, we, wa, wd, pwe, pwa, pwd, pv, pd, dn, rdy};
  endfunction

  function automatic logic [127:0] obs_vec();
    return pk(rf_we, rf_waddr, rf_wdata, pos_we, pos_waddr, pos_wdata, pxl_valid, pxl_data,
              done, in_ready);
  endfunction

  logic [127:0] idle_vec;
  logic [127:0] exp_q[$];
  logic         pr_q[$];

  // Expected cycles after accept: rf lanes, pos lanes, single pos, then pixel with w stalls.
  task automatic build_model(input logic [3:0] fl, input logic [3:0] rd,
                             input logic [127:0] rv, input logic [127:0] ldv, input int w);
    logic [31:0] rr [4];
    logic [31:0] ll [4];
    logic [127:0] e;
    exp_q.delete();
    pr_q.delete();
    for (int k = 0; k < 4; k++) begin
      rr[k] = rv[32*k +: 32];
      ll[k] = ldv[32*k +: 32];
    end
    if (fl[0])
      for (int k = 0; k < 4; k++) begin
        exp_q.push_back(pk(1'b1, 4'((int'(rd) + k) % 16), ll[k], 0, 0, 0, 0, 0, 0, 0));
        pr_q.push_back(1'($urandom));
      end
    if (fl[1])
      for (int k = 0; k < 4; k++) begin
        exp_q.push_back(pk(0, 0, 0, 1'b1, 2'(k), rr[k], 0, 0, 0, 0));
        pr_q.push_back(1'($urandom));
      end
    if (fl[2]) begin
      exp_q.push_back(pk(0, 0, 0, 1'b1, rd[1:0], rr[0], 0, 0, 0, 0));
      pr_q.push_back(1'($urandom));
    end
    if (fl[3]) begin
      for (int k = 0; k <= w; k++) begin
        exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 1'b1, ll[0], 0, 0));
        pr_q.push_back(k == w);
      end
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_back();
      e[1] = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic junk_inputs(input logic v);
    in_valid = v;
    {wr_pxl_in, wr_pos_in, wr_mul_pos_in, wr_mul_reg_in} = 4'($urandom);
    rd_in = 4'($urandom);
    {r1_in, r2_in, r3_in, r4_in} = {$urandom, $urandom, $urandom, $urandom};
    {load1_in, load2_in, load3_in, load4_in} = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic run_bundle(input string tag, input logic [3:0] fl, input logic [3:0] rd,
                            input logic [127:0] rv, input logic [127:0] ldv, input int w);
    int n;
    build_model(fl, rd, rv, ldv, w);
    n = exp_q.size();
    @(posedge clk); #1;
    in_valid = 1'b1;
    {wr_pxl_in, wr_pos_in, wr_mul_pos_in, wr_mul_reg_in} = fl;
    rd_in = rd;
    {r4_in, r3_in, r2_in, r1_in} = rv;
    {load4_in, load3_in, load2_in, load1_in} = ldv;
    pxl_ready = 1'($urandom);
    @(negedge clk);
    check_val({tag, "_rdy"}, {127'd0, in_ready}, {127'd0, 1'b1});
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      junk_inputs(1'($urandom));
      pxl_ready = pr_q[i];
      @(negedge clk);
      check_val($sformatf("%s_c%0d", tag, i + 1), obs_vec(), exp_q[i]);
    end
    @(posedge clk); #1;
    junk_inputs(1'b0);
    pxl_ready = 1'($urandom);
    @(negedge clk);
    check_val({tag, "_idle"}, obs_vec(), idle_vec);
  endtask

  initial begin
    logic [127:0] rv, ldv;
    idle_vec = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1);

    // Reset held for two edges, then released.
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      junk_inputs(1'b1);
      @(negedge clk);
      check_val($sformatf("reset_c%0d", i), obs_vec(), 128'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    junk_inputs(1'b0);
    @(negedge clk);
    check_val("reset_rel", obs_vec(), idle_vec);

    run_bundle("mreg_wrap", 4'b0001, 4'd14, {32'h4, 32'h3, 32'h2, 32'h1},
               {32'hD, 32'hC, 32'hB, 32'hA}, 0);
    run_bundle("all_flags", 4'b1111, 4'd2, {32'd4, 32'd3, 32'd2, 32'd1},
               {$urandom, $urandom, $urandom, 32'h55}, 0);
    run_bundle("pxl_bp", 4'b1000, 4'd0, 128'd0, {96'd0, 32'hCAFE_F00D}, 5);
    run_bundle("empty", 4'b0000, 4'd7, {4{32'h1234_5678}}, {4{32'h9ABC_DEF0}}, 0);

    // Reset while the register-file lanes are in flight.
    @(posedge clk); #1;
    in_valid = 1'b1;
    {wr_pxl_in, wr_pos_in, wr_mul_pos_in, wr_mul_reg_in} = 4'b0001;
    rd_in = 4'd5;
    {load4_in, load3_in, load2_in, load1_in} = {32'h44, 32'h33, 32'h22, 32'h11};
    @(posedge clk); #1;
    junk_inputs(1'b0);
    @(negedge clk);
    check_val("mrst_l0", obs_vec(), pk(1, 4'd5, 32'h11, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("mrst_l1", obs_vec(), pk(1, 4'd6, 32'h22, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    @(negedge clk);
    check_val("mrst_zero", obs_vec(), 128'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val($sformatf("mrst_idle%0d", i), obs_vec(), idle_vec);
      @(posedge clk); #1;
    end
    run_bundle("post_rst_pos", 4'b0100, 4'd9, {32'h0, 32'h0, 32'h0, 32'hBEEF},
               128'd0, 0);

    for (int t = 0; t < 40; t++) begin
      rv  = {$urandom, $urandom, $urandom, $urandom};
      ldv = {$urandom, $urandom, $urandom, $urandom};
      run_bundle($sformatf("rnd%0d", t), 4'($urandom), 4'($urandom), rv, ldv,
                 int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
